// File: rtl/onehot_enc_pkg.sv
// onehot_enc_pkg: shared sizes, FSM state type and code-to-mask helper
// for the request encoder.
package onehot_enc_pkg;
    localparam int N_IN   = 12;
    localparam int CODE_W = 4;

    typedef enum logic {IDLE, PRESENT} state_t;

    function automatic logic [N_IN-1:0] code_mask(input logic [CODE_W-1:0] c);
        return N_IN'(1) << c;
    endfunction
endpackage

// File: rtl/prio_enc.sv
// prio_enc: combinational lowest-set-bit finder.
// Returns the index of the lowest set bit and whether any bit is set.
module prio_enc
    import onehot_enc_pkg::*;
(
    input  logic [N_IN-1:0]   vec,
    output logic [CODE_W-1:0] idx,
    output logic              any
);
    always_comb begin
        idx = '0;
        // Scan downward so the lowest set bit is the last writer.
        for (int i = N_IN - 1; i >= 0; i--)
            if (vec[i]) idx = CODE_W'(i);
        any = |vec;
    end
endmodule

// File: rtl/onehot_req_encoder.sv
// onehot_req_encoder: gathers request pulses into a pending register and
// serialises them as binary indices, lowest first, over valid/ready.
module onehot_req_encoder
    import onehot_enc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   req_i,
    input  logic              clr_i,
    output logic [CODE_W-1:0] code_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [N_IN-1:0]   pending_o,
    output logic              ovf_o
);
    state_t            state, state_n;
    logic [N_IN-1:0]   pending, acc_mask, rem;
    logic [CODE_W-1:0] code, code_n, idle_idx, rem_idx;
    logic              acc, ovf, ovf_n, idle_any, rem_any;

    prio_enc u_idle (.vec(pending), .idx(idle_idx), .any(idle_any));
    prio_enc u_rem  (.vec(rem),     .idx(rem_idx),  .any(rem_any));

    always_comb begin
        acc      = (state == PRESENT) && ready_i;
        acc_mask = acc ? code_mask(code) : '0;
        rem      = (pending & ~acc_mask) | req_i;
        // A re-request of the bit being accepted is a fresh request, not overflow.
        ovf_n    = clr_i ? 1'b0 : ovf | (|(req_i & pending & ~acc_mask));
        state_n  = state;
        code_n   = code;
        if (clr_i) begin
            state_n = IDLE;
            code_n  = '0;
        end else if (state == IDLE) begin
            state_n = idle_any ? PRESENT : IDLE;
            code_n  = idle_any ? idle_idx : code;
        end else if (acc) begin
            state_n = rem_any ? PRESENT : IDLE;
            code_n  = rem_any ? rem_idx : code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            code    <= '0;
            ovf     <= 1'b0;
        end else begin
            state   <= state_n;
            pending <= clr_i ? '0 : rem;
            code    <= code_n;
            ovf     <= ovf_n;
        end
    end

    assign code_o    = code;
    assign valid_o   = (state == PRESENT);
    assign pending_o = pending;
    assign ovf_o     = ovf;
endmodule

// File: tb/tb_onehot_req_encoder.sv
// tb_onehot_req_encoder: table-driven scoreboard checks plus hand-written
// sequences for reset, backpressure, re-request, overflow and flush.
module tb_onehot_req_encoder;
    import onehot_enc_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N_IN-1:0]   req_i = '0;
    logic              clr_i = 1'b0;
    logic              ready_i = 1'b0;
    logic [CODE_W-1:0] code_o;
    logic              valid_o;
    logic [N_IN-1:0]   pending_o;
    logic              ovf_o;

    int total = 0;
    int bad = 0;
    int exp_q[$];

    typedef struct {
        logic [N_IN-1:0] req;
        int              n_codes;
        int              first_code;
    } vec_t;
    vec_t vecs[6];

    onehot_req_encoder dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .clr_i(clr_i),
        .code_o(code_o), .valid_o(valid_o), .ready_i(ready_i),
        .pending_o(pending_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Run with ready_i=1, popping the scoreboard on every accept, until idle.
    task automatic drain(input string name, input int max_cycles);
        int n = 0;
        ready_i = 1'b1;
        while ((exp_q.size() != 0 || valid_o) && n < max_cycles) begin
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    check({name, " unexpected code"}, int'(code_o), -1);
                end else begin
                    check({name, " code"}, int'(code_o), exp_q.pop_front());
                end
            end
            step();
            n++;
        end
        check({name, " drained in budget"}, int'(n < max_cycles), 1);
        check({name, " pending empty"}, int'(pending_o), 0);
        exp_q.delete();
    endtask

    task automatic push_bits(input logic [N_IN-1:0] r);
        for (int b = 0; b < N_IN; b++)
            if (r[b]) exp_q.push_back(b);
    endtask

    initial begin
        vecs[0] = '{12'b1000_0010_0100, 3, 2};
        vecs[1] = '{12'h001, 1, 0};
        vecs[2] = '{12'h800, 1, 11};
        vecs[3] = '{12'hFFF, 12, 0};
        vecs[4] = '{12'hA50, 4, 4};
        vecs[5] = '{12'h00C, 2, 2};

        // Reset with all requests asserted
        req_i = 12'hFFF;
        repeat (3) step();
        check("reset valid", int'(valid_o), 0);
        check("reset pending", int'(pending_o), 0);
        check("reset ovf", int'(ovf_o), 0);
        check("reset code", int'(code_o), 0);
        rst_n = 1'b1;
        step();
        req_i = '0;
        check("post-reset pending", int'(pending_o), 12'hFFF);
        check("post-reset valid latency", int'(valid_o), 0);
        push_bits(12'hFFF);
        step();
        check("post-reset first valid", int'(valid_o), 1);
        drain("post-reset", 40);
        check("post-reset ovf", int'(ovf_o), 0);

        // Table: single-cycle patterns with the scoreboard
        foreach (vecs[v]) begin
            int cnt;
            ready_i = 1'b1;
            req_i = vecs[v].req;
            cnt = 0;
            for (int b = 0; b < N_IN; b++) if (vecs[v].req[b]) cnt++;
            check("table code count", cnt, vecs[v].n_codes);
            push_bits(vecs[v].req);
            check("table first code", exp_q[0], vecs[v].first_code);
            step();
            req_i = '0;
            check("table valid latency", int'(valid_o), 0);
            step();
            drain("table", 40);
        end

        // Burst: consecutive codes 2, 5, 11
        ready_i = 1'b1;
        req_i = 12'b1000_0010_0100;
        step();
        req_i = '0;
        step();
        check("burst v0", int'(valid_o), 1);
        check("burst c0", int'(code_o), 2);
        step();
        check("burst v1", int'(valid_o), 1);
        check("burst c1", int'(code_o), 5);
        step();
        check("burst v2", int'(valid_o), 1);
        check("burst c2", int'(code_o), 11);
        step();
        check("burst end valid", int'(valid_o), 0);
        check("burst end pending", int'(pending_o), 0);

        // Backpressure: code 7 held while bit 1 arrives
        ready_i = 1'b0;
        req_i = 12'h080;
        step();
        req_i = '0;
        step();
        for (int k = 0; k < 5; k++) begin
            req_i = (k == 0) ? 12'h002 : '0;
            check("bp hold valid", int'(valid_o), 1);
            check("bp hold code", int'(code_o), 7);
            step();
        end
        req_i = '0;
        check("bp pending", int'(pending_o), 12'h082);
        ready_i = 1'b1;
        check("bp accept code", int'(code_o), 7);
        step();
        check("bp next valid", int'(valid_o), 1);
        check("bp next code", int'(code_o), 1);
        step();
        check("bp idle", int'(valid_o), 0);
        check("bp ovf", int'(ovf_o), 0);

        // Same-bit re-request during accept
        ready_i = 1'b0;
        req_i = 12'h008;
        step();
        req_i = '0;
        step();
        check("rereq first code", int'(code_o), 3);
        ready_i = 1'b1;
        req_i = 12'h008;
        step();
        req_i = '0;
        check("rereq valid again", int'(valid_o), 1);
        check("rereq code again", int'(code_o), 3);
        check("rereq ovf", int'(ovf_o), 0);
        step();
        check("rereq idle", int'(valid_o), 0);
        check("rereq ovf after", int'(ovf_o), 0);

        // Overflow: duplicate request on pending bit 9
        ready_i = 1'b0;
        req_i = 12'h200;
        step();
        req_i = '0;
        step();
        check("ovf code", int'(code_o), 9);
        req_i = 12'h200;
        step();
        req_i = '0;
        check("ovf set", int'(ovf_o), 1);
        step();
        check("ovf sticky", int'(ovf_o), 1);
        ready_i = 1'b1;
        check("ovf code held", int'(code_o), 9);
        step();
        check("ovf single code", int'(valid_o), 0);
        check("ovf pending", int'(pending_o), 0);
        step();
        check("ovf still sticky", int'(ovf_o), 1);

        // Flush with a concurrent accept and request
        ready_i = 1'b0;
        req_i = 12'h0F0;
        step();
        req_i = '0;
        step();
        check("flush pre valid", int'(valid_o), 1);
        check("flush pre pending", int'(pending_o), 12'h0F0);
        clr_i = 1'b1;
        ready_i = 1'b1;
        req_i = 12'h001;
        step();
        clr_i = 1'b0;
        req_i = '0;
        check("flush valid", int'(valid_o), 0);
        check("flush pending", int'(pending_o), 0);
        check("flush ovf", int'(ovf_o), 0);
        for (int k = 0; k < 3; k++) begin
            check("flush quiet", int'(valid_o), 0);
            step();
        end

        // Asynchronous reset mid-handshake
        ready_i = 1'b0;
        req_i = 12'h030;
        step();
        req_i = '0;
        step();
        check("arst pre valid", int'(valid_o), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst valid", int'(valid_o), 0);
        check("arst pending", int'(pending_o), 0);
        check("arst code", int'(code_o), 0);
        step();
        rst_n = 1'b1;
        step();
        check("arst after valid", int'(valid_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/onehot_req_encoder.md
Name: onehot_req_encoder

Overview:
- Companion to the 4-to-12 select decoder, working in the opposite direction.
- Collects up to 12 one-hot/multi-hot request lines (interrupt/event sources, register-write strobes) into a pending register.
- Serialises each pending bit as a 4-bit binary index over a valid/ready handshake, lowest index first.
- Feeds the control unit, which decodes the index back to a one-hot select.

Parameters:
- N_IN, 12, number of request lines; legal range 2..16.
- CODE_W, 4, width of the encoded index; must satisfy 2^CODE_W >= N_IN.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_i  input  N_IN  request pulses, sampled every cycle, OR-ed into pending
- clr_i  input  1  synchronous flush of pending, output stage and ovf
- code_o  output  CODE_W  binary index of the presented request
- valid_o  output  1  code_o holds a request
- ready_i  input  1  consumer accepts code_o when valid_o && ready_i
- pending_o  output  N_IN  current pending register, for debug/status
- ovf_o  output  1  sticky: a request arrived for a bit already pending

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: pending=0, code_o=0, valid_o=0, ovf_o=0, FSM=IDLE.
- Pending update per edge: pending <= (pending & ~acc_mask) | req_i.
  - acc_mask is one-hot of code_o when valid_o && ready_i, otherwise 0.
  - A new req on the bit being accepted in the same cycle leaves that bit set; the request is not lost.
- ovf_o sets when req_i[k] && pending[k] && !(accept of k this cycle). It clears only on clr_i or reset.
- FSM states:
  - IDLE: valid_o=0. If pending != 0, load code_o = lowest set index of pending, go to PRESENT.
  - PRESENT: valid_o=1 and code_o held stable until accept. No preemption by lower-index arrivals.
  - On accept, compute rem = (pending & ~acc_mask) | req_i.
    - If rem != 0: load the lowest index of rem, stay in PRESENT. This gives back-to-back throughput of 1 code per cycle.
    - Else: go to IDLE, valid_o=0.
- Latency: req_i sampled at edge N appears in pending after edge N. From IDLE, valid_o rises after edge N+1, a 2-cycle request-to-valid latency. Exception: when a concurrent accept computes rem, the request can appear after edge N.
- clr_i has priority over everything, including an accept in the same cycle. After the edge: pending=0, valid_o=0, ovf_o=0, FSM=IDLE. req_i in the clr_i cycle is discarded.
- Unused code values (N_IN..2^CODE_W-1) are never produced.
- ready_i while valid_o=0 is ignored.
- Asserting rst_n low mid-handshake drops all pending state immediately (asynchronous); no partial output.

Decomposition:
- Package onehot_enc_pkg holds:
  - constants N_IN and CODE_W;
  - state typedef {IDLE, PRESENT};
  - function for the one-hot mask from a code.
- Sub-module prio_enc holds the lowest-set-bit finder.
  - Purely combinational; vector in, CODE_W index plus any_set out.
  - Instantiated twice: on pending for IDLE, and on rem for the accept path.

Test Plan:
- Reset: hold rst_n=0 with req_i=12'hFFF. Required: valid_o=0, pending_o=0, ovf_o=0; pending_o=12'hFFF one cycle after release.
- Multi-hot burst: req_i=12'b1000_0010_0100 for one cycle, ready_i=1. Required: codes 2, 5, 11 on consecutive cycles, then valid_o=0, pending_o=0.
- Backpressure: pending bit 7, ready_i=0 for 5 cycles while req_i bit 1 pulses. Required: code_o=7 held stable; after ready_i=1, code 1 next cycle.
- Same-bit re-request: code_o=3 accepted in the same cycle req_i[3]=1. Required: code 3 presented again next cycle, ovf_o stays 0.
- Overflow: pending bit 9 set, ready_i=0, pulse req_i[9]. Required: ovf_o=1 sticky; only one code 9 is emitted.
- Flush: pending=12'h0F0, valid_o=1, assert clr_i together with ready_i. Required: next cycle valid_o=0, pending_o=0, ovf_o=0, no further codes.
